// File: rtl/echo_delay_if.sv
// Sample-strobe bus between the audio source/sink and the echo stage.
// Latency: none (wiring only).
// Backpressure: none; the echo stage flags strobes it cannot take via Overrun.
//   master: drives ready/SampleIn/EchoEn/DelayLen/Decay, receives SampleOut/SampleValid/Overrun
//   slave : the echo stage itself
interface echo_delay_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
) ();
    logic                     ready;
    logic signed [WIDTH-1:0]  SampleIn;
    logic                     EchoEn;
    logic [ADDR_W-1:0]        DelayLen;
    logic [2:0]               Decay;
    logic signed [WIDTH-1:0]  SampleOut;
    logic                     SampleValid;
    logic                     Overrun;

    modport master (
        output ready, SampleIn, EchoEn, DelayLen, Decay,
        input  SampleOut, SampleValid, Overrun
    );

    modport slave (
        input  ready, SampleIn, EchoEn, DelayLen, Decay,
        output SampleOut, SampleValid, Overrun
    );
endinterface

// File: rtl/echo_delay.sv
// Single-tap feedback echo: y = sat(x + d*Decay/8), d read DelayLen samples back from a circular buffer.
// Latency: ready in cycle N -> SampleValid/SampleOut in cycle N+3; busy in N+1..N+2.
// Backpressure: none; a strobe arriving while busy is dropped and sets sticky Overrun.
//   ports: clk, reset (async active-high), bus (echo_delay_if.slave: strobe, sample, controls, result)
module echo_delay #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    echo_delay_if.slave bus
);
    localparam int PW = WIDTH + 4;  // product width: WIDTH x 4-bit signed gain

    localparam logic [ADDR_W:0]         FILL_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic signed [PW-1:0]    SAT_HI   = {{5{1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]    SAT_LO   = {{5{1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, CALC} state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       wr_ptr;
    logic [ADDR_W:0]         fill_cnt;   // writes since reset, saturating; masks stale RAM
    logic signed [WIDTH-1:0] x_q;
    logic signed [WIDTH-1:0] d_q;
    logic [ADDR_W-1:0]       d_len_q;
    logic                    en_q;
    logic [2:0]              g_q;

    logic signed [WIDTH-1:0] mem [1 << ADDR_W];
    logic signed [WIDTH-1:0] rd_dat;
    logic [ADDR_W-1:0]       d_len_in;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    wr_en;
    logic signed [WIDTH-1:0] wr_dat;
    logic signed [PW-1:0]    p;
    logic signed [PW-1:0]    s;
    logic signed [WIDTH-1:0] y;

    // A delay of 0 would read the slot about to be written; treat it as 1.
    assign d_len_in = (bus.DelayLen == '0) ? ADDR_W'(1) : bus.DelayLen;
    assign rd_addr  = wr_ptr - d_len_in;

    // Read address is only meaningful in IDLE; the registered read lands in READ.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

    // Sum kept at product width so the saturation compare sees the true value;
    // >>> on the signed product floors toward negative infinity.
    assign p = $signed({{4{d_q[WIDTH-1]}}, d_q}) * $signed({{(PW-3){1'b0}}, g_q});
    assign s = $signed({{4{x_q[WIDTH-1]}}, x_q}) + (p >>> 3);

    always_comb begin
        y = x_q;
        if (en_q) begin
            if (s > SAT_HI) begin
                y = {1'b0, {(WIDTH-1){1'b1}}};
            end else if (s < SAT_LO) begin
                y = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                y = s[WIDTH-1:0];
            end
        end
    end

    // Bypass writes zeros so the buffer drains while echo is off.
    assign wr_en  = (state == CALC);
    assign wr_dat = en_q ? y : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            fill_cnt        <= '0;
            x_q             <= '0;
            d_q             <= '0;
            d_len_q         <= '0;
            en_q            <= 1'b0;
            g_q             <= '0;
            bus.SampleOut   <= '0;
            bus.SampleValid <= 1'b0;
            bus.Overrun     <= 1'b0;
        end else begin
            bus.SampleValid <= 1'b0;
            if (bus.ready && (state != IDLE)) begin
                bus.Overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.ready) begin
                        x_q     <= bus.SampleIn;
                        d_len_q <= d_len_in;
                        en_q    <= bus.EchoEn;
                        g_q     <= bus.Decay;
                        state   <= READ;
                    end
                end
                READ: begin
                    d_q   <= (fill_cnt < {1'b0, d_len_q}) ? '0 : rd_dat;
                    state <= CALC;
                end
                CALC: begin
                    bus.SampleOut   <= y;
                    bus.SampleValid <= 1'b1;
                    wr_ptr          <= wr_ptr + ADDR_W'(1);
                    if (fill_cnt != FILL_MAX) begin
                        fill_cnt <= fill_cnt + (ADDR_W+1)'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_echo_delay.sv
// Testbench for echo_delay: directed phases with randomized samples against a history-based echo model.
// Latency checked: SampleValid exactly three cycles after each accepted strobe.
// Backpressure checked: dropped strobes, sticky Overrun, reset mid-operation.
module tb_echo_delay;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hist[$];   // every value written to the buffer since the last reset, oldest first

    echo_delay_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    echo_delay #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int floor_div8(input int v);
        if (v >= 0) return v / 8;
        return -((-v + 7) / 8);
    endfunction

    // Echo reads the value written dlen samples ago; before that many writes exist it reads 0.
    function automatic int model(input int x, input bit en, input int dl, input int g);
        int dlen, n, d, y;
        dlen = (dl == 0) ? 1 : dl;
        n    = hist.size();
        d    = (n >= dlen) ? hist[n - dlen] : 0;
        y    = en ? sat16(x + floor_div8(d * g)) : x;
        hist.push_back(en ? y : 0);
        return y;
    endfunction

    // Called at a negedge; returns at the negedge where the DUT is idle again.
    task automatic send(input int x, input bit en, input int dl, input int g,
                        input string tag, output int got);
        int exp;
        bus.SampleIn = 16'(x);
        bus.EchoEn   = en;
        bus.DelayLen = 12'(dl);
        bus.Decay    = 3'(g);
        bus.ready    = 1'b1;
        exp = model(x, en, dl, g);
        @(negedge clk);
        bus.ready    = 1'b0;
        // Controls move while busy; only the values seen at the strobe may matter.
        bus.SampleIn = 16'($urandom);
        bus.EchoEn   = ~en;
        bus.DelayLen = 12'($urandom);
        bus.Decay    = 3'($urandom);
        check({tag, "_busy1"}, 32'(bus.SampleValid), 0);
        @(negedge clk);
        check({tag, "_busy2"}, 32'(bus.SampleValid), 0);
        @(negedge clk);
        check({tag, "_vld"}, 32'(bus.SampleValid), 1);
        check({tag, "_out"}, 32'(bus.SampleOut), exp);
        got = 32'(bus.SampleOut);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
    endtask

    initial begin
        int got;
        int imp[13];
        int pulses;
        int last;
        int exp;

        reset        = 1'b0;
        bus.ready    = 1'b0;
        bus.SampleIn = '0;
        bus.EchoEn   = 1'b0;
        bus.DelayLen = '0;
        bus.Decay    = '0;

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("rst_out", 32'(bus.SampleOut), 0);
        check("rst_vld", 32'(bus.SampleValid), 0);
        check("rst_ovr", 32'(bus.Overrun), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hist.delete();

        // Impulse response, one strobe every 20 clocks
        for (int i = 0; i < 13; i++) begin
            send((i == 0) ? 16000 : 0, 1'b1, 4, 4, "imp", got);
            imp[i] = got;
            repeat (17) @(negedge clk);
        end
        check("imp_0", imp[0], 16000);
        check("imp_4", imp[4], 8000);
        check("imp_8", imp[8], 4000);
        check("imp_12", imp[12], 2000);
        check("imp_5", imp[5], 0);

        // Random echo with small delays (including 0) and random gain
        for (int i = 0; i < 60; i++) begin
            send($signed(16'($urandom)), 1'b1, $urandom_range(0, 6), $urandom_range(0, 7), "rnd", got);
        end

        // Bypass: output equals input, buffer flushed
        for (int i = 0; i < 40; i++) begin
            send($signed(16'($urandom)), 1'b0, $urandom_range(0, 4095), $urandom_range(0, 7), "byp", got);
        end
        for (int i = 0; i < 10; i++) begin
            send(0, 1'b1, 2, 7, "flush", got);
            check("flush_zero", got, 0);
        end

        // Saturation
        for (int i = 0; i < 5; i++) begin
            send(30000, 1'b1, 1, 7, "satp", got);
        end
        check("satp_hold", got, 32767);
        for (int i = 0; i < 6; i++) begin
            send(-30000, 1'b1, 1, 7, "satn", got);
        end
        check("satn_hold", got, -32768);

        // Floor of negative scaled echo: d=-1, gain 7/8 -> -1
        send(0, 1'b0, 1, 7, "flr_clr", got);
        send(-1, 1'b1, 1, 7, "flr_seed", got);
        send(0, 1'b1, 1, 7, "flr", got);
        check("flr_m1", got, -1);

        // Fill masking: load every RAM word with 0x7FFF, reset, then echoes must stay masked
        do_reset();
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            send(32767, 1'b1, 1, 0, "pre", got);
        end
        do_reset();
        for (int i = 0; i < 110; i++) begin
            exp = $signed(16'($urandom)) / 4;
            send(exp, 1'b1, 100, 7, "mask", got);
            if (i < 100) check("mask_eq_in", got, exp);
        end

        // Pointer wrap with the maximum delay
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            send((i == 10) ? 8192 : 0, 1'b1, 4095, 4, "wrap", got);
            if (i == 10)   check("wrap_imp", got, 8192);
            if (i == 4105) check("wrap_echo", got, 4096);
        end
        check("wrap_no_ovr", 32'(bus.Overrun), 0);

        // Overrun: strobe held for two cycles, second one dropped
        bus.SampleIn = 16'(1234);
        bus.EchoEn   = 1'b0;
        bus.DelayLen = 12'(1);
        bus.Decay    = 3'(0);
        bus.ready    = 1'b1;
        exp = model(1234, 1'b0, 1, 0);
        @(negedge clk);
        bus.SampleIn = 16'(-555);
        @(negedge clk);
        bus.ready = 1'b0;
        pulses = 0;
        last   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.SampleValid === 1'b1) begin
                pulses++;
                last = 32'(bus.SampleOut);
            end
        end
        check("ovr_pulses", pulses, 1);
        check("ovr_out", last, exp);
        check("ovr_flag", 32'(bus.Overrun), 1);

        // Reset one cycle after an accepted strobe: nothing emerges, outputs cleared
        bus.SampleIn = 16'(777);
        bus.ready    = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.SampleValid !== 1'b0) pulses++;
        end
        check("rstmid_pulses", pulses, 0);
        check("rstmid_out", 32'(bus.SampleOut), 0);
        check("rstmid_ovr", 32'(bus.Overrun), 0);
        send(100, 1'b1, 3, 7, "post_rst", got);
        check("post_rst_val", got, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
